snes_stream_gen: RTL and testbench

Bring-up stimulus source that drives the SNES-side video and audio stream into the HDMI converter when no PPU/DSP is present. It generates NTSC SNES raster timing (`dotclk`, `hblank`, `vblank`, `xs`, `ys`), selectable test patterns on `rgb5`, a per-line `snes_refresh` window, and a 32 kHz stereo tone with `audio_ready`/`audio_en` flow control. It obeys the converter's `pause` (frame-sync) request exactly as the real SNES core does.

---
 rtl/snes_stream_gen.sv | 177 +++++++++++++++++
 tb/tb_snes_stream_gen.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snes_stream_gen.sv
// SNES-side stimulus source: NTSC raster timing, test patterns, refresh window and a
// 32 kHz square-wave tone, all frozen by the converter's frame-sync pause.
module snes_stream_gen #(
  parameter int unsigned DOT_DIV     = 4,
  parameter int unsigned H_TOTAL     = 341,
  parameter int unsigned H_ACT_START = 22,
  parameter int unsigned V_TOTAL     = 262,
  parameter int unsigned V_ACTIVE    = 224,
  parameter int unsigned REFRESH_DOT = 134,
  parameter int unsigned REFRESH_LEN = 40,
  parameter int unsigned AUDIO_DIV   = 671,
  parameter int unsigned TONE_HALF   = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pause,
  input  logic [1:0]  pattern_sel,
  output logic        dotclk,
  output logic        hblank,
  output logic        vblank,
  output logic [8:0]  xs,
  output logic [8:0]  ys,
  output logic [14:0] rgb5,
  output logic        snes_refresh,
  output logic [15:0] audio_l,
  output logic [15:0] audio_r,
  output logic        audio_ready,
  input  logic        audio_en
);

  localparam int unsigned MW = (DOT_DIV > 2) ? $clog2(DOT_DIV) : 1;
  localparam int unsigned HW = ($clog2(H_TOTAL) > 9) ? $clog2(H_TOTAL) : 9;
  localparam int unsigned VW = ($clog2(V_TOTAL) > 9) ? $clog2(V_TOTAL) : 9;
  localparam int unsigned RW = $clog2(REFRESH_LEN + 1);
  localparam int unsigned AW = (AUDIO_DIV > 2) ? $clog2(AUDIO_DIV) : 1;
  localparam int unsigned PW = (TONE_HALF > 1) ? $clog2(2 * TONE_HALF) : 1;

  localparam logic [MW-1:0] MLast     = MW'(DOT_DIV - 1);
  localparam logic [MW-1:0] MHalf     = MW'(DOT_DIV / 2);
  localparam logic [HW-1:0] HLast     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HActStart = HW'(H_ACT_START);
  localparam logic [HW-1:0] HActEnd   = HW'(H_ACT_START + 256);
  localparam logic [HW-1:0] HRefresh  = HW'(REFRESH_DOT);
  localparam logic [VW-1:0] VLast     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VActive   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VYMax     = VW'(255);
  localparam logic [RW-1:0] RLenM1    = RW'(REFRESH_LEN - 1);
  localparam logic [AW-1:0] ALast     = AW'(AUDIO_DIV - 1);
  localparam logic [PW-1:0] PLast     = PW'(2 * TONE_HALF - 1);
  localparam logic [PW-1:0] PHalf     = PW'(TONE_HALF);

  logic [MW-1:0] m_q, m_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          field_q, field_d;
  logic [7:0]    frame_q, frame_d;
  logic [1:0]    pat_q, pat_d;
  logic [RW-1:0] ref_q, ref_d;
  logic [AW-1:0] adiv_q, adiv_d;
  logic [PW-1:0] phase_q, phase_d;

  logic          m_wrap, h_wrap, v_wrap, a_wrap, ref_start;
  logic          dotclk_c, hblank_c, vblank_c, ref_c;
  logic [7:0]    x_c, y_c;
  logic [14:0]   rgb_c;
  logic [15:0]   sample_c;

  // Raster, refresh and audio counters: next-state.
  always_comb begin
    m_wrap  = (m_q == MLast);
    h_wrap  = (h_q == HLast);
    v_wrap  = (v_q == VLast);
    m_d     = m_wrap ? '0 : m_q + MW'(1);
    h_d     = h_q;
    v_d     = v_q;
    field_d = field_q;
    frame_d = frame_q;
    if (m_wrap) h_d = h_wrap ? '0 : h_q + HW'(1);
    if (m_wrap && h_wrap) v_d = v_wrap ? '0 : v_q + VW'(1);
    if (m_wrap && h_wrap && v_wrap) begin
      field_d = ~field_q;
      frame_d = frame_q + 8'd1;
    end
    pat_d = (m_q == '0 && h_q == '0 && v_q == '0) ? pattern_sel : pat_q;

    // Window opens on the first clock of REFRESH_DOT and lasts REFRESH_LEN unpaused clocks.
    ref_start = (h_q == HRefresh) && (m_q == '0);
    ref_c     = ref_start || (ref_q != '0);
    ref_d     = ref_q;
    if (ref_start)          ref_d = RLenM1;
    else if (ref_q != '0)   ref_d = ref_q - RW'(1);

    a_wrap  = (adiv_q == ALast);
    adiv_d  = a_wrap ? '0 : adiv_q + AW'(1);
    phase_d = phase_q;
    if (a_wrap) phase_d = (phase_q == PLast) ? '0 : phase_q + PW'(1);
  end

  // Counter state; everything holds while the converter requests a pause.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      m_q     <= '0;
      h_q     <= '0;
      v_q     <= '0;
      field_q <= 1'b0;
      frame_q <= '0;
      pat_q   <= '0;
      ref_q   <= '0;
      adiv_q  <= '0;
      phase_q <= '0;
    end else if (!pause) begin
      m_q     <= m_d;
      h_q     <= h_d;
      v_q     <= v_d;
      field_q <= field_d;
      frame_q <= frame_d;
      pat_q   <= pat_d;
      ref_q   <= ref_d;
      adiv_q  <= adiv_d;
      phase_q <= phase_d;
    end
  end

  // Video/audio values decoded from the current counter state.
  always_comb begin
    dotclk_c = (m_q >= MHalf);
    hblank_c = (h_q < HActStart) || (h_q >= HActEnd);
    vblank_c = (v_q >= VActive);
    x_c      = 8'(h_q - HActStart);
    y_c      = (v_q > VYMax) ? 8'hFF : v_q[7:0];
    case (pat_q)
      2'd0:    rgb_c = {{5{x_c[7]}}, {5{x_c[6]}}, {5{x_c[5]}}};
      2'd1:    rgb_c = {x_c[7:3] ^ y_c[7:3], y_c[7:3], x_c[7:3]};
      2'd2:    rgb_c = (x_c[3] ^ y_c[3]) ? 15'h7FFF : 15'h0000;
      default: rgb_c = (x_c == frame_q) ? 15'h7FFF : 15'h7C00;
    endcase
    if (hblank_c || vblank_c) begin
      rgb_c = '0;
      x_c   = '0;
    end
    // +8192 / -8192 in two's complement.
    sample_c = (phase_q < PHalf) ? 16'h2000 : 16'hE000;
  end

  // Registered outputs, one clock behind the counters; only the strobe is touched on pause.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dotclk       <= 1'b0;
      hblank       <= 1'b1;
      vblank       <= 1'b0;
      xs           <= '0;
      ys           <= '0;
      rgb5         <= '0;
      snes_refresh <= 1'b0;
      audio_l      <= '0;
      audio_r      <= '0;
      audio_ready  <= 1'b0;
    end else if (pause) begin
      audio_ready  <= 1'b0;
    end else begin
      dotclk       <= dotclk_c;
      hblank       <= hblank_c;
      vblank       <= vblank_c;
      xs           <= {x_c, dotclk_c};
      ys           <= {field_q, y_c};
      rgb5         <= rgb_c;
      snes_refresh <= ref_c;
      // The tone keeps running when the sink refuses a sample, so pitch is unaffected.
      audio_ready  <= a_wrap && audio_en;
      if (a_wrap) begin
        audio_l <= sample_c;
        audio_r <= sample_c;
      end
    end
  end

endmodule

// File: tb/tb_snes_stream_gen.sv
// Bench for snes_stream_gen: per-clock scoreboard against a tick-count reference model,
// plus directed checks of raster, refresh, pause, audio flow control and pattern latch.
module tb_snes_stream_gen;

  // Shrunk geometry keeps whole frames short; the active window is still 256 dots.
  localparam int DD = 4, HT = 280, HAS = 16, VT = 10, VA = 9;
  localparam int RD = 134, RL = 40, AD = 61, TH = 4;
  localparam int LINE  = DD * HT;
  localparam int FRAME = LINE * VT;

  logic clk = 1'b0, resetn = 1'b0, pause = 1'b0, audio_en = 1'b1;
  logic [1:0] pattern_sel = 2'd0;
  logic dotclk, hblank, vblank, snes_refresh, audio_ready;
  logic [8:0] xs, ys;
  logic [14:0] rgb5;
  logic [15:0] audio_l, audio_r;

  always #5 clk = ~clk;

  snes_stream_gen #(
    .DOT_DIV(DD), .H_TOTAL(HT), .H_ACT_START(HAS), .V_TOTAL(VT), .V_ACTIVE(VA),
    .REFRESH_DOT(RD), .REFRESH_LEN(RL), .AUDIO_DIV(AD), .TONE_HALF(TH)
  ) dut (
    .clk(clk), .resetn(resetn), .pause(pause), .pattern_sel(pattern_sel),
    .dotclk(dotclk), .hblank(hblank), .vblank(vblank), .xs(xs), .ys(ys), .rgb5(rgb5),
    .snes_refresh(snes_refresh), .audio_l(audio_l), .audio_r(audio_r),
    .audio_ready(audio_ready), .audio_en(audio_en)
  );

  typedef logic [69:0] vec_t;
  vec_t q[$];
  vec_t last_e = '0;
  vec_t snap;
  int tests = 0, fails = 0, cyc = 0;
  int t = 0;
  logic [1:0] pat_m = 2'd0;
  logic [15:0] ea = '0;

  int nrise, nblue, nwhite, nvb, tog, tog_c1, tog_c2, n, c;
  logic prev_dc, prev_fld, s;
  logic [14:0] px_40_7, px_8_0, px_8_8;

  function automatic vec_t obs_vec();
    return {dotclk, hblank, vblank, xs, ys, rgb5, snes_refresh, audio_l, audio_r, audio_ready};
  endfunction

  task automatic chk(input string tag, input vec_t o, input vec_t e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Expected outputs after the coming edge, derived from the count of unpaused ticks.
  task automatic model(output vec_t e);
    int m, p, h, v, f, k;
    logic dc, hb, vb, bl, rf, rdy;
    logic [7:0] xb, yb;
    logic [14:0] px;
    if (!resetn) begin
      e = {1'b0, 1'b1, 1'b0, 9'd0, 9'd0, 15'd0, 1'b0, 16'd0, 16'd0, 1'b0};
      t = 0;
      pat_m = 2'd0;
      ea = '0;
    end else if (pause) begin
      e = last_e;
      e[0] = 1'b0;
    end else begin
      m = t % DD;
      p = t % LINE;
      h = p / DD;
      v = (t / LINE) % VT;
      f = t / FRAME;
      dc = (m >= DD / 2);
      hb = (h < HAS) || (h >= HAS + 256);
      vb = (v >= VA);
      bl = hb || vb;
      xb = 8'(h - HAS);
      yb = (v > 255) ? 8'd255 : 8'(v);
      case (pat_m)
        2'd0:    px = {{5{xb[7]}}, {5{xb[6]}}, {5{xb[5]}}};
        2'd1:    px = {xb[7:3] ^ yb[7:3], yb[7:3], xb[7:3]};
        2'd2:    px = (xb[3] ^ yb[3]) ? 15'h7FFF : 15'h0000;
        default: px = (xb == 8'(f)) ? 15'h7FFF : 15'h7C00;
      endcase
      if (bl) px = '0;
      rf = (p >= RD * DD) && (p < RD * DD + RL);
      rdy = 1'b0;
      if (t % AD == AD - 1) begin
        k = t / AD;
        ea = ((k % (2 * TH)) < TH) ? 16'h2000 : 16'hE000;
        rdy = audio_en;
      end
      if (t % FRAME == 0) pat_m = pattern_sel;
      e = {dc, hb, vb, (bl ? 8'd0 : xb), dc, 1'(f % 2), yb, px, rf, ea, ea, rdy};
      t++;
    end
  endtask

  task automatic step();
    vec_t e, o;
    model(e);
    last_e = e;
    q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    o = obs_vec();
    e = q.pop_front();
    chk($sformatf("stream@%0d", cyc), o, e);
  endtask

  task automatic run_steps(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      step();
      if (dotclk && !prev_dc && !hblank && !vblank) begin
        nrise++;
        if (xs[8:1] >= 8'd32 && xs[8:1] <= 8'd63 && rgb5 == 15'h001F) nblue++;
        if (xs[8:1] >= 8'd224 && rgb5 == 15'h7FFF) nwhite++;
        if (xs[8:1] == 8'd40 && ys[7:0] == 8'd7) px_40_7 = rgb5;
        if (xs[8:1] == 8'd8 && ys[7:0] == 8'd0) px_8_0 = rgb5;
        if (xs[8:1] == 8'd8 && ys[7:0] == 8'd8) px_8_8 = rgb5;
      end
      prev_dc = dotclk;
      if (ys[8] != prev_fld) begin
        tog++;
        if (tog == 1) tog_c1 = cyc;
        else tog_c2 = cyc;
      end
      prev_fld = ys[8];
      if (vblank) nvb++;
    end
  endtask

  task automatic run_to(input int pos);
    int k = 0;
    while ((t % FRAME) != pos && k <= FRAME) begin
      run_steps(1);
      k++;
    end
    chk("run_to_bound", vec_t'(k <= FRAME), 1);
  endtask

  task automatic wait_pulse(output int k);
    k = 0;
    do begin
      run_steps(1);
      k++;
    end while (!audio_ready && k < 2 * AD);
    chk("pulse_seen", audio_ready, 1);
  endtask

  initial begin
    // 1. Reset values, then one full frame of colour bars.
    resetn = 1'b0;
    repeat (3) step();
    chk("reset_vals", {dotclk, hblank, vblank, xs, ys, rgb5, snes_refresh, audio_ready},
        {1'b0, 1'b1, 1'b0, 9'd0, 9'd0, 15'd0, 1'b0, 1'b0});
    chk("reset_audio", {audio_l, audio_r}, 0);
    resetn = 1'b1;
    prev_dc = dotclk;
    prev_fld = ys[8];
    nrise = 0; nblue = 0; nwhite = 0;
    run_steps(FRAME);
    chk("active_rises", nrise, VA * 256);
    chk("bars_blue", nblue, VA * 32);
    chk("bars_white", nwhite, VA * 32);

    // 2. Refresh window position and length, then a long pause inside it.
    run_to(2 * LINE);
    n = 0;
    do begin run_steps(1); n++; end while (!snes_refresh && n < LINE);
    chk("refresh_delay", n - 1, RD * DD);
    n = 0;
    while (snes_refresh && n < LINE) begin n++; run_steps(1); end
    chk("refresh_len", n, RL);

    run_to(3 * LINE);
    n = 0;
    do begin run_steps(1); n++; end while (!snes_refresh && n < LINE);
    run_steps(9);
    chk("refresh_before_pause", snes_refresh, 1);
    snap = obs_vec();
    pause = 1'b1;
    run_steps(5000);
    chk("pause_frozen", obs_vec(), snap & ~70'd1);
    chk("pause_refresh", snes_refresh, 1);
    pause = 1'b0;
    n = 10;
    while (snes_refresh && n <= LINE) begin
      run_steps(1);
      if (snes_refresh) n++;
    end
    chk("refresh_len_paused", n, RL);

    // 3. Audio strobe period, tone half-period, and backpressure.
    audio_en = 1'b1;
    wait_pulse(n);
    wait_pulse(n);
    chk("audio_period", n, AD);
    s = audio_l[15];
    for (int i = 0; i < 2 * TH && audio_l[15] == s; i++) wait_pulse(n);
    s = audio_l[15];
    c = 0;
    for (int i = 0; i < 2 * TH && audio_l[15] == s; i++) begin wait_pulse(n); c++; end
    chk("tone_half", c, TH);
    chk("audio_lr_equal", audio_r, audio_l);
    audio_en = 1'b0;
    c = 0;
    for (int i = 0; i < 100 * AD; i++) begin
      run_steps(1);
      if (audio_ready) c++;
    end
    chk("no_pulse_disabled", c, 0);
    audio_en = 1'b1;
    wait_pulse(n);

    // 4/5. Pattern change mid-frame takes effect next frame; field toggles once per frame.
    run_to(0);
    tog = 0; nvb = 0;
    px_40_7 = 'x; px_8_0 = 'x; px_8_8 = 'x;
    run_steps(5 * LINE);
    pattern_sel = 2'd2;
    run_steps(FRAME - 5 * LINE);
    chk("bars_still_latched", px_40_7, 15'h001F);
    chk("vblank_lines", nvb, (VT - VA) * LINE);
    px_40_7 = 'x;
    run_steps(FRAME);
    chk("checker_8_0", px_8_0, 15'h7FFF);
    chk("checker_8_8", px_8_8, 15'h0000);
    chk("checker_40_7", px_40_7, 15'h7FFF);
    chk("field_toggles", tog, 2);
    chk("frame_len", tog_c2 - tog_c1, FRAME);

    // 6. Reset mid-line, raster restarts from line 0.
    run_to(5 * LINE + 200 * DD);
    resetn = 1'b0;
    run_steps(1);
    chk("midreset_out", {hblank, rgb5, xs, snes_refresh, audio_ready},
        {1'b1, 15'd0, 9'd0, 1'b0, 1'b0});
    resetn = 1'b1;
    run_steps(1);
    chk("restart_v0", {hblank, ys}, {1'b1, 9'd0});
    run_steps(LINE);
    chk("restart_line1", ys, 9'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
